sha256_msg_schedule: RTL and testbench

//  Message-schedule stage downstream of the 512-bit block buffer. Latches the assembled block (data_out) on start.

---
 rtl/sha256_msg_schedule.sv | 134 +++++++++++++
 tb/tb_sha256_msg_schedule.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: streams W[0..ROUNDS-1] from a 16-word sliding window.
// Optional SHA256_SCHED_KCONST_EN adds k_out carrying the round constant K[round_idx].
module sha256_msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [511:0] block_in,
  input  logic         start,
  input  logic         clear,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic         w_valid,
  output logic [5:0]   round_idx,
  output logic         busy,
  output logic         done
`ifdef SHA256_SCHED_KCONST_EN
  ,
  output logic [31:0]  k_out
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] win [16];
  logic [5:0]  t;
  logic [31:0] w_new;
  logic        load;
  logic        shift;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign w_new     = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
  assign w_out     = win[0];
  assign round_idx = t;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, handshake outputs and datapath strobes
  always_comb begin
    state_nxt = state;
    w_valid   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!clear && start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        w_valid = 1'b1;
        busy    = 1'b1;
        if (clear) begin
          state_nxt = IDLE;
        end else if (w_ready) begin
          if (t == T_LAST) state_nxt = DONE;
          else             shift     = 1'b1;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window load/shift and round counter; t saturates at the last round
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
      t <= '0;
    end else if (clear) begin
      t <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++)
        win[i] <= block_in[511 - 32*i -: 32];
      t <= '0;
    end else if (shift) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= w_new;
      t       <= t + 6'd1;
    end else if (state == DONE) begin
      t <= '0;
    end
  end

`ifdef SHA256_SCHED_KCONST_EN
  localparam logic [31:0] KTAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  assign k_out = w_valid ? KTAB[t] : '0;
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Testbench for sha256_msg_schedule: directed blocks, scoreboard queue,
// independent negedge monitor. Define SHA256_SCHED_KCONST_EN to cover k_out.
module tb_sha256_msg_schedule;

  localparam int ROUNDS = 64;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic [511:0] block_in = '0;
  logic         start = 1'b0;
  logic         clear = 1'b0;
  logic         w_ready = 1'b0;
  logic [31:0]  w_out;
  logic         w_valid;
  logic [5:0]   round_idx;
  logic         busy;
  logic         done;
`ifdef SHA256_SCHED_KCONST_EN
  logic [31:0]  k_out;
`endif

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] w;
    bit          last;
    bit          abc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   exp_done = 1'b0;

  localparam logic [511:0] ABC = {32'h61626380, 448'b0, 32'h00000018};
  localparam logic [511:0] ALT = {16{32'hdeadbeef}};

  sha256_msg_schedule #(.ROUNDS(ROUNDS)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .block_in  (block_in),
    .start     (start),
    .clear     (clear),
    .w_ready   (w_ready),
    .w_out     (w_out),
    .w_valid   (w_valid),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
`ifdef SHA256_SCHED_KCONST_EN
    ,
    .k_out     (k_out)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Full 64-entry reference expansion, queued as expected outputs
  task automatic push_block(input logic [511:0] blk, input bit abc);
    logic [31:0] w [64];
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = s1(w[i-2]) + w[i-7] + s0(w[i-15]) + w[i-16];
    for (int i = 0; i < ROUNDS; i++)
      sb.push_back('{6'(i), w[i], (i == ROUNDS - 1), abc});
  endtask

  function automatic bit rdy(input int mode, input int cyc);
    int p;
    p = (cyc - 1) % 4;
    if (mode == 0) return 1'b1;
    return (p == 0) || (p == 3);
  endfunction

  // Monitor: compares presented word to queue head, pops on accept
  always @(negedge clk) begin
    if (!n_rst) begin
      exp_done = 1'b0;
    end else begin
      chk("done", 32'(done), 32'(exp_done));
      exp_done = 1'b0;
`ifdef SHA256_SCHED_KCONST_EN
      if (!w_valid) chk("k_idle", k_out, 32'h0);
`endif
      if (clear) begin
        sb.delete();
      end else if (w_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got %08h idx %0d, expected none",
                   w_out, round_idx);
        end else begin
          chk("w_out", w_out, sb[0].w);
          chk("round_idx", 32'(round_idx), 32'(sb[0].idx));
          if (sb[0].abc) begin
            case (sb[0].idx)
              6'd0, 6'd16: chk("abc_w", w_out, 32'h61626380);
              6'd15:       chk("abc_w15", w_out, 32'h00000018);
              6'd17:       chk("abc_w17", w_out, 32'h000f0000);
              6'd63:       chk("abc_w63", w_out, 32'h12b1edeb);
              default: ;
            endcase
          end
`ifdef SHA256_SCHED_KCONST_EN
          case (sb[0].idx)
            6'd0:  chk("k0", k_out, 32'h428a2f98);
            6'd1:  chk("k1", k_out, 32'h71374491);
            6'd63: chk("k63", k_out, 32'hc67178f2);
            default: ;
          endcase
`endif
          if (w_ready) begin
            exp_done = sb[0].last;
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic run_block(input logic [511:0] blk, input bit abc,
                           input int mode, input bit inj_start,
                           input bit inj_clear);
    bit finished;
    @(posedge clk); #1;
    block_in = blk;
    start    = 1'b1;
    clear    = 1'b0;
    push_block(blk, abc);
    w_ready  = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    block_in = ~blk;
    finished = 1'b0;
    for (int cyc = 1; cyc < 1000 && !finished; cyc++) begin
      if (cyc == 1) begin
        chk("latency_valid", 32'(w_valid), 32'h1);
        chk("busy_run", 32'(busy), 32'h1);
      end
      w_ready = rdy(mode, cyc);
      start   = 1'b0;
      clear   = 1'b0;
      if (inj_start && w_valid && round_idx == 6'd20) begin
        start    = 1'b1;
        block_in = ALT;
      end
      if (inj_clear && w_valid && round_idx == 6'd30) begin
        clear    = 1'b1;
        start    = 1'b1;
        block_in = ALT;
        finished = 1'b1;
      end
      @(posedge clk); #1;
      if (done) finished = 1'b1;
    end
    start = 1'b0;
    clear = 1'b0;
    if (!finished) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: got no done, expected done within 1000 cycles");
    end else if (inj_clear) begin
      chk("clr_valid", 32'(w_valid), 32'h0);
      chk("clr_busy", 32'(busy), 32'h0);
      chk("clr_idx", 32'(round_idx), 32'h0);
      repeat (3) @(posedge clk);
      #1;
      chk("clr_stays_idle", 32'(w_valid), 32'h0);
    end else begin
      chk("busy_done", 32'(busy), 32'h1);
      @(posedge clk); #1;
      chk("busy_idle", 32'(busy), 32'h0);
      chk("idx_idle", 32'(round_idx), 32'h0);
    end
  endtask

  initial begin
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w_out", w_out, 32'h0);
    chk("rst_w_valid", 32'(w_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_idx", 32'(round_idx), 32'h0);
    n_rst = 1'b1;

    run_block(ABC, 1'b1, 0, 1'b0, 1'b0);
    run_block(ABC, 1'b1, 1, 1'b0, 1'b0);
    run_block(ABC, 1'b1, 0, 1'b1, 1'b0);
    run_block(ABC, 1'b1, 0, 1'b0, 1'b1);
    run_block(ABC, 1'b1, 0, 1'b0, 1'b0);
    run_block(ALT, 1'b0, 1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
